// File: rtl/qrd_out_collector.sv
// QRD output collector: frames four beats of the four output lanes into a 4x4 R
// matrix, screens the strictly-lower triangle against TOL and queues matrices in a 2-entry buffer.

module qrd_oc_screen #(
  parameter int DW  = 17,
  parameter int TOL = 16
) (
  input  logic [DW-1:0] i_x,
  output logic          o_bad
);
  logic [DW:0] w_ext;
  logic [DW:0] w_mag;

  // one extra bit so the most negative code still has a representable magnitude
  assign w_ext = {i_x[DW-1], i_x};
  assign w_mag = i_x[DW-1] ? ((DW+1)'(0) - w_ext) : w_ext;
  assign o_bad = (w_mag > (DW+1)'(TOL));
endmodule

module qrd_out_collector #(
  parameter int DW      = 17,
  parameter int LATENCY = 6,
  parameter int TOL     = 16,
  parameter int CNT_W   = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [CNT_W-1:0]    i_stream_len,
  input  logic [DW-1:0]       i_lane0,
  input  logic [DW-1:0]       i_lane1,
  input  logic [DW-1:0]       i_lane2,
  input  logic [DW-1:0]       i_lane3,
  output logic                o_mat_valid,
  input  logic                i_mat_ready,
  output logic [16*DW-1:0]    o_mat_data,
  output logic                o_mat_tri_err,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_ovf
);
  localparam int NUM_LANES = 4;
  localparam int MW        = NUM_LANES*NUM_LANES*DW;
  localparam int WCW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP} state_t;

  state_t                             r_state;
  logic [WCW-1:0]                     r_wcnt;
  logic [CNT_W-1:0]                   r_len;
  logic [CNT_W-1:0]                   r_mcnt;
  logic [1:0]                         r_beat;
  logic [2:0][NUM_LANES-1:0][DW-1:0]  r_cols;
  logic [MW-1:0]                      r_stg_data;
  logic                               r_stg_err;
  logic                               r_push;
  logic                               r_fin;
  logic                               r_done;

  logic [1:0][MW-1:0]                 r_mem;
  logic [1:0]                         r_err;
  logic                               r_rd;
  logic [1:0]                         r_cnt;
  logic                               r_ovf;

  logic [NUM_LANES-1:0][DW-1:0]       w_lanes;
  logic [2:0][NUM_LANES-1:0]          w_bad;
  logic                               w_samp;
  logic                               w_start_acc;
  logic                               w_pop;
  logic                               w_full;
  logic                               w_acc;
  logic                               w_wr;

  assign w_lanes = {i_lane3, i_lane2, i_lane1, i_lane0};

  // Columns 0..2 are complete when beat 3 arrives; column 3 has no sub-diagonal entries.
  for (genvar c = 0; c < 3; c++) begin : g_col
    for (genvar r = 0; r < NUM_LANES; r++) begin : g_row
      if (r > c) begin : g_chk
        qrd_oc_screen #(.DW(DW), .TOL(TOL)) u_scr (
          .i_x   (r_cols[c][r]),
          .o_bad (w_bad[c][r])
        );
      end else begin : g_upper
        assign w_bad[c][r] = 1'b0;
      end
    end
  end

  // Beat 0 is taken on the final WAIT edge so beat 0 lands exactly LATENCY edges after start.
  assign w_samp = ((r_state == S_WAIT) && (r_wcnt == '0)) ||
                  ((r_state == S_CAP) && (r_mcnt != r_len));
  assign w_start_acc = (r_state == S_IDLE) && i_start && (i_stream_len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wcnt     <= '0;
      r_len      <= '0;
      r_mcnt     <= '0;
      r_beat     <= '0;
      r_cols     <= '0;
      r_stg_data <= '0;
      r_stg_err  <= 1'b0;
      r_push     <= 1'b0;
      r_fin      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_done <= 1'b0;
      r_fin  <= r_push && (r_mcnt == r_len);
      if (w_samp) begin
        case (r_beat)
          2'd0: r_cols[0] <= w_lanes;
          2'd1: r_cols[1] <= w_lanes;
          2'd2: r_cols[2] <= w_lanes;
          default: begin
            r_stg_data <= {w_lanes, r_cols};
            r_stg_err  <= |w_bad;
            r_push     <= 1'b1;
            r_mcnt     <= r_mcnt + CNT_W'(1);
          end
        endcase
        r_beat <= r_beat + 2'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_stream_len != '0) begin
              r_len   <= i_stream_len;
              r_wcnt  <= WCW'(LATENCY - 1);
              r_mcnt  <= '0;
              r_beat  <= '0;
              r_state <= S_WAIT;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_wcnt == '0) r_state <= S_CAP;
          else              r_wcnt  <= r_wcnt - WCW'(1);
        end
        S_CAP: begin
          if (r_fin) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pop  = (r_cnt != 2'd0) && i_mat_ready;
  assign w_full = (r_cnt == 2'd2);
  assign w_acc  = r_push && (!w_full || w_pop);
  assign w_wr   = r_rd ^ r_cnt[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_err <= '0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
      r_ovf <= 1'b0;
    end else begin
      if (w_acc) begin
        r_mem[w_wr] <= r_stg_data;
        r_err[w_wr] <= r_stg_err;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_acc} - {1'b0, w_pop};
      if (w_start_acc)          r_ovf <= 1'b0;
      else if (r_push && !w_acc) r_ovf <= 1'b1;
    end
  end

  assign o_mat_valid   = (r_cnt != 2'd0);
  assign o_mat_data    = r_mem[r_rd];
  assign o_mat_tri_err = r_err[r_rd];
  assign o_busy        = (r_state == S_WAIT) || (r_state == S_CAP);
  assign o_done        = r_done;
  assign o_ovf         = r_ovf;
endmodule

// File: tb/tb_qrd_out_collector.sv
// Randomized scoreboard bench for qrd_out_collector: the driver schedules expected
// matrices, a negedge monitor models the 2-deep buffer and compares every output.

module tb_qrd_out_collector;
  localparam int DW = 17, LAT = 6, TOL = 16, CNT_W = 12, MW = 16*DW;

  logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_mat_ready = 1'b0;
  logic [CNT_W-1:0] i_stream_len = '0;
  logic [DW-1:0] i_lane0 = '0, i_lane1 = '0, i_lane2 = '0, i_lane3 = '0;
  logic o_mat_valid, o_mat_tri_err, o_busy, o_done, o_ovf;
  logic [MW-1:0] o_mat_data;

  qrd_out_collector #(.DW(DW), .LATENCY(LAT), .TOL(TOL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stream_len(i_stream_len),
    .i_lane0(i_lane0), .i_lane1(i_lane1), .i_lane2(i_lane2), .i_lane3(i_lane3),
    .o_mat_valid(o_mat_valid), .i_mat_ready(i_mat_ready), .o_mat_data(o_mat_data),
    .o_mat_tri_err(o_mat_tri_err), .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0, bad = 0;

  typedef struct { int at; logic [MW-1:0] d; logic e; } ev_t;
  ev_t pend[$];
  ev_t mq[$];
  int m_bstart = 0, m_bend = 0, m_done = -1, m_sedge = -1;
  logic exp_ovf = 1'b0;
  logic [DW-1:0] mats [0:7][0:3][0:3];  // [matrix][row][col]

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] flat_of(input int k);
    logic [MW-1:0] f = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        f[(4*c+r)*DW +: DW] = mats[k][r][c];
    return f;
  endfunction

  function automatic logic err_of(input int k);
    logic e = 1'b0;
    int v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < r; c++) begin
        v = int'($signed(mats[k][r][c]));
        if (v < 0) v = -v;
        if (v > TOL) e = 1'b1;
      end
    return e;
  endfunction

  task automatic set_base(input int k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mats[k][r][c] = (r > c) ? '0 : DW'(32'h100*(r+1) + c);
  endtask

  task automatic rand_mats(input int n);
    int v;
    for (int k = 0; k < n; k++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (r > c) begin
            case ($urandom_range(0, 5))
              0: mats[k][r][c] = DW'($urandom());
              1: mats[k][r][c] = 17'h10000;
              default: begin
                v = int'($urandom_range(0, 2*TOL+4)) - (TOL+2);
                mats[k][r][c] = DW'(v);
              end
            endcase
          end else begin
            mats[k][r][c] = DW'($urandom());
          end
        end
  endtask

  // Monitor: compare against the buffer model, then apply the push/pop of the coming edge.
  always @(negedge clk) begin
    ev_t h;
    logic pop;
    if (!rst_n) begin
      mq.delete();
      pend.delete();
      exp_ovf = 1'b0;
      m_bstart = 0; m_bend = 0; m_done = -1; m_sedge = -1;
    end else begin
      chk("valid", o_mat_valid, mq.size() != 0);
      chk("busy", o_busy, (cyc >= m_bstart) && (cyc < m_bend));
      chk("done", o_done, cyc == m_done);
      chk("ovf", o_ovf, exp_ovf);
      if (mq.size() != 0) begin
        chk("data", o_mat_data, mq[0].d);
        chk("tri_err", o_mat_tri_err, mq[0].e);
      end
      if (cyc + 1 == m_sedge) exp_ovf = 1'b0;
      pop = (mq.size() != 0) && i_mat_ready;
      if (pend.size() != 0 && pend[0].at == cyc + 1) begin
        h = pend.pop_front();
        if (mq.size() < 2 || pop) mq.push_back(h);
        else exp_ovf = 1'b1;
      end
      if (pop) void'(mq.pop_front());
    end
  end

  // rdy_off: ready from edge t+rdy_off on (-1 = random); ign_at/rst_at relative edges (-1 = none).
  task automatic run_stream(input int n, input int rdy_off, input int ign_at, input int rst_at);
    int t, last, rel;
    @(posedge clk); #1;
    t = cyc + 1;
    i_start = 1'b1;
    i_stream_len = CNT_W'(n);
    m_sedge  = (n > 0) ? t : -1;
    m_bstart = t;
    m_bend   = (n == 0) ? t : t + LAT + 4*n + 1;
    m_done   = (n == 0) ? t : t + LAT + 4*n + 1;
    for (int k = 0; k < n; k++)
      pend.push_back('{at: t + LAT + 4*k + 4, d: flat_of(k), e: err_of(k)});
    last = m_bend + 6;
    if (rdy_off >= 0 && t + rdy_off + 6 > last) last = t + rdy_off + 6;
    for (int e = t; e <= last; e++) begin
      if (e != t) begin
        i_start = (ign_at >= 0) && (e == t + ign_at);
        if (i_start) i_stream_len = CNT_W'(7);
      end
      rel = e - t - LAT;
      if (rel >= 0 && rel < 4*n) begin
        i_lane0 = mats[rel/4][0][rel%4];
        i_lane1 = mats[rel/4][1][rel%4];
        i_lane2 = mats[rel/4][2][rel%4];
        i_lane3 = mats[rel/4][3][rel%4];
      end else begin
        i_lane0 = DW'($urandom()); i_lane1 = DW'($urandom());
        i_lane2 = DW'($urandom()); i_lane3 = DW'($urandom());
      end
      i_mat_ready = (rdy_off < 0) ? 1'($urandom_range(0, 1)) : (e >= t + rdy_off);
      if (rst_at >= 0 && e == t + rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", o_mat_valid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        i_start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_mat_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mat_valid", o_mat_valid, 1'b0);
    chk("rst_mat_data", o_mat_data, '0);
    chk("rst_tri_err", o_mat_tri_err, 1'b0);
    chk("rst_busy0", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_ovf", o_ovf, 1'b0);
    rst_n = 1'b1;

    set_base(0);
    run_stream(1, 0, -1, -1);

    set_base(0); set_base(1); set_base(2);
    mats[0][3][0] = 17'h1FFEF;
    mats[1][3][0] = 17'h1FFF0;
    mats[2][3][0] = 17'h10000;
    run_stream(3, 0, -1, -1);

    rand_mats(3);
    run_stream(3, LAT + 30, -1, -1);      // third matrix dropped
    rand_mats(3);
    run_stream(3, LAT + 12, -1, -1);      // pop coincides with push at full
    run_stream(0, 0, -1, -1);
    rand_mats(2);
    run_stream(2, 0, LAT + 5, -1);        // start during capture ignored
    rand_mats(2);
    run_stream(2, LAT + 40, -1, LAT + 7); // reset with a matrix buffered
    rand_mats(1);
    run_stream(1, 0, -1, -1);

    for (int i = 0; i < 10; i++) begin
      n = int'($urandom_range(1, 5));
      rand_mats(n);
      run_stream(n, -1, -1, -1);
    end

    @(negedge clk);
    chk("drain", 32'(mq.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
